// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: 16-bit instruction fetch stage with a PC register and an IF/ID
// pipeline register. Handles decode back-pressure (stall) and redirects from
// execute. Optional single-step debug feature enabled by the macro
// FETCH_SINGLE_STEP_EN (adds ports step_mode / step_pulse and state STEP_WAIT).
module fetch_unit (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] iaddr,
    input  logic [15:0] idata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc2,
    output logic        if_valid
`ifdef FETCH_SINGLE_STEP_EN
    ,
    input  logic        step_mode,
    input  logic        step_pulse
`endif
);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_STEP_WAIT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [15:0] pc;
    logic        step_on;
    logic        step_go;
    logic        fetch_ok;
    logic        accept;

`ifdef FETCH_SINGLE_STEP_EN
    assign step_on = step_mode;
    assign step_go = step_pulse;
`else
    // Without the step feature the block never enters STEP_WAIT.
    assign step_on = 1'b0;
    assign step_go = 1'b0;
`endif

    // The instruction memory is addressed straight from the PC register.
    assign iaddr = pc;

    // Decide whether this cycle accepts a fetch and where the FSM goes next.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fetch_ok   = 1'b1;
        accept     = 1'b0;
        state_next = ST_RUN;

        // STEP_WAIT only lets a fetch through when a step pulse arrives.
        if (state == ST_STEP_WAIT) begin
            fetch_ok = step_go;
        end
        accept = !redirect && !stall && fetch_ok;

        // Step mode parks the block in STEP_WAIT (stalls there drop pulses);
        // otherwise stall selects HOLD and its absence returns to RUN.
        if (step_on) begin
            state_next = ST_STEP_WAIT;
        end else if (stall) begin
            state_next = ST_HOLD;
        end else begin
            state_next = ST_RUN;
        end
    end

    // PC, IF/ID register and FSM state update; redirect beats stall and step.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc       <= 16'h0000;
            if_instr <= 16'h0000;
            if_pc    <= 16'h0000;
            if_pc2   <= 16'h0002;
            if_valid <= 1'b0;
            state    <= step_on ? ST_STEP_WAIT : ST_RUN;
        end else begin
            state <= state_next;
            if (redirect) begin
                // Bit 0 of the target is ignored; the IF/ID payload is held
                // and only its valid flag is dropped (one-bubble penalty).
                pc       <= {redirect_pc[15:1], 1'b0};
                if_valid <= 1'b0;
            end else if (accept) begin
                if_instr <= idata;
                if_pc    <= pc;
                if_pc2   <= pc + 16'h0002;
                if_valid <= 1'b1;
                pc       <= pc + 16'h0002;
            end else if (!stall) begin
                // Idle STEP_WAIT cycle: decode is not stalled, so it must see
                // a bubble instead of re-issuing the last stepped instruction.
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: self-checking bench for fetch_unit. A ROM returns
// idata = iaddr + 0x1000. A spec-level model (PC plus the IF/ID fields)
// predicts every output each cycle through directed and random steps.
// Step-mode checks are compiled in when FETCH_SINGLE_STEP_EN is defined.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] iaddr;
    logic [15:0] idata;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc2;
    logic        if_valid;
`ifdef FETCH_SINGLE_STEP_EN
    logic        step_mode;
    logic        step_pulse;
`endif

    int tests  = 0;
    int failed = 0;

    // Reference model state: next fetch address and the decode-side view.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic [15:0] m_pc2;
    logic        m_valid;

    always #5 clock = ~clock;

    // Combinational instruction ROM.
    assign idata = iaddr + 16'h1000;

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .iaddr       (iaddr),
        .idata       (idata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc2      (if_pc2),
        .if_valid    (if_valid)
`ifdef FETCH_SINGLE_STEP_EN
        ,
        .step_mode   (step_mode),
        .step_pulse  (step_pulse)
`endif
    );

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".iaddr"},    iaddr,           m_pc);
        check({tag, ".if_instr"}, if_instr,        m_instr);
        check({tag, ".if_pc"},    if_pc,           m_ipc);
        check({tag, ".if_pc2"},   if_pc2,          m_pc2);
        check({tag, ".if_valid"}, {15'b0, if_valid}, {15'b0, m_valid});
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic cycle(input string tag, input logic rst, input logic st,
                         input logic rd, input logic [15:0] rp);
        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rp;
        if (rst) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
            m_pc2 = 16'h0002; m_valid = 1'b0;
        end else if (rd) begin
            m_pc    = rp & 16'hFFFE;
            m_valid = 1'b0;
        end else if (!st) begin
            m_instr = m_pc + 16'h1000;
            m_ipc   = m_pc;
            m_pc2   = m_pc + 16'h0002;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'h0002;
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
`ifdef FETCH_SINGLE_STEP_EN
        step_mode = 1'b0; step_pulse = 1'b0;
`endif
        m_pc = 16'h0; m_instr = 16'h0; m_ipc = 16'h0; m_pc2 = 16'h2; m_valid = 1'b0;

        // Reset values.
        cycle("rst0", 1, 0, 0, 16'h0);
        cycle("rst1", 1, 0, 0, 16'h0);
        check("rst.if_pc2_lit", if_pc2, 16'h0002);
        check("rst.iaddr_lit", iaddr, 16'h0000);

        // Free run: first edge after reset fetches 0x0000.
        cycle("run0", 0, 0, 0, 16'h0);
        check("run0.if_pc_lit", if_pc, 16'h0000);
        check("run0.valid_lit", {15'b0, if_valid}, 16'h0001);
        cycle("run1", 0, 0, 0, 16'h0);
        cycle("run2", 0, 0, 0, 16'h0);
        cycle("run3", 0, 0, 0, 16'h0);
        check("run3.if_pc_lit", if_pc, 16'h0006);
        check("run3.if_instr_lit", if_instr, 16'h1006);

        // Stall three cycles at pc=0x0008, then release.
        for (int i = 0; i < 3; i++) cycle("stall", 0, 1, 0, 16'h0);
        check("stall.iaddr_lit", iaddr, 16'h0008);
        check("stall.if_pc_lit", if_pc, 16'h0006);
        cycle("release", 0, 0, 0, 16'h0);
        check("release.if_pc_lit", if_pc, 16'h0008);
        check("release.if_instr_lit", if_instr, 16'h1008);

        // Redirect with stall together, odd target.
        cycle("rd_st", 0, 1, 1, 16'h0003);
        check("rd_st.iaddr_lit", iaddr, 16'h0002);
        check("rd_st.valid_lit", {15'b0, if_valid}, 16'h0000);
        cycle("rd_st_hold", 0, 1, 0, 16'h0);
        cycle("rd_st_go", 0, 0, 0, 16'h0);
        check("rd_st_go.if_instr_lit", if_instr, 16'h1002);

        // PC wrap at 0xFFFE.
        cycle("wrap_rd", 0, 0, 1, 16'hFFFE);
        cycle("wrap_f0", 0, 0, 0, 16'h0);
        check("wrap_f0.if_pc_lit", if_pc, 16'hFFFE);
        check("wrap_f0.if_instr_lit", if_instr, 16'h0FFE);
        cycle("wrap_f1", 0, 0, 0, 16'h0);
        check("wrap_f1.if_pc_lit", if_pc, 16'h0000);

        // Back-to-back redirects: only the last target is fetched.
        cycle("b2b_a", 0, 0, 1, 16'h0100);
        cycle("b2b_b", 0, 0, 1, 16'h0200);
        cycle("b2b_f", 0, 0, 0, 16'h0);
        check("b2b_f.if_pc_lit", if_pc, 16'h0200);

        // Reset overrides stall and redirect.
        cycle("rst_mid", 1, 1, 1, 16'h1234);
        check("rst_mid.iaddr_lit", iaddr, 16'h0000);
        cycle("rst_after", 0, 0, 0, 16'h0);
        check("rst_after.if_pc_lit", if_pc, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  16'($urandom));
        end

`ifdef FETCH_SINGLE_STEP_EN
        // Single-step: nothing fetched until a pulse, one fetch per pulse.
        step_mode = 1'b1; stall = 1'b0; redirect = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("step.idle_valid", {15'b0, if_valid}, 16'h0000);
        check("step.idle_iaddr", iaddr, 16'h0000);
        step_pulse = 1'b1;
        @(posedge clock); #1;
        step_pulse = 1'b0;
        check("step.p1_if_pc", if_pc, 16'h0000);
        check("step.p1_valid", {15'b0, if_valid}, 16'h0001);
        repeat (4) @(posedge clock);
        #1;
        check("step.gap_iaddr", iaddr, 16'h0002);
        step_pulse = 1'b1;
        @(posedge clock); #1;
        step_pulse = 1'b0;
        check("step.p2_if_pc", if_pc, 16'h0002);
        step_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Port list:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- iaddr  out  16  byte address to the instruction memory; equals the PC register, combinational, bit 0 always 0.
- idata  in  16  instruction word returned combinationally by the instruction memory for iaddr.
- stall  in  1  decode/execute back-pressure; holds PC and IF/ID register.
- redirect  in  1  taken branch/jump from execute.
- redirect_pc  in  16  new PC; bit 0 ignored (forced 0).
- if_instr  out  16  registered instruction to decode.
- if_pc  out  16  registered address of if_instr.
- if_pc2  out  16  registered if_pc+2, the branch base for decode.
- if_valid  out  1  if_instr is a real, non-squashed instruction.
- step_mode  in  1  single-step enable (REQ-017 only).
- step_pulse  in  1  one-cycle step request, already debounced (REQ-017 only).

Function
REQ-003 PC register SHALL be 16 bits and advance by 2 per accepted fetch; 0xFFFE+2 wraps to 0x0000, with no flag.
REQ-004 Fetch latency SHALL be one cycle: a word presented on idata for PC=p appears on if_instr, with if_pc=p, on the next rising edge when the fetch is accepted.
REQ-005 Accepted fetch (RUN, no stall, no redirect): if_instr<=idata, if_pc<=pc, if_pc2<=pc+2, if_valid<=1, pc<=pc+2.
REQ-006 Redirect SHALL take priority over stall and step: pc<={redirect_pc[15:1],0}, if_valid<=0, and if_instr/if_pc/if_pc2 are held.
REQ-007 Stall without redirect SHALL hold pc, if_instr, if_pc, if_pc2 and if_valid unchanged.
REQ-008 Redirect and stall asserted together SHALL load the PC and clear if_valid; the stall then applies from the next cycle.
REQ-009 States: RUN, HOLD, STEP_WAIT.
- RUN -> HOLD on stall.
- HOLD -> RUN when stall is low.
- STEP_WAIT used only per REQ-017.
REQ-010 The cycle after a redirect SHALL fetch from redirect_pc (one-bubble penalty).
REQ-011 Consecutive redirects on back-to-back cycles SHALL each load the PC; only the last target is fetched.
REQ-012 No combinational path SHALL exist from idata to any output.

Reset
REQ-013 On reset: pc=0x0000 (iaddr=0x0000), if_instr=0x0000, if_pc=0x0000, if_valid=0.
REQ-014 On reset, if_pc2 SHALL be 0x0002 and the state SHALL be RUN, or STEP_WAIT if the step feature is present and step_mode=1.
REQ-015 Reset SHALL override redirect, stall and step in the same cycle; reset mid-stall or mid-redirect returns to REQ-013 and REQ-014 values.
REQ-016 The first rising edge after reset deasserts SHALL perform a fetch of address 0x0000 (if_valid=1) unless stall or redirect is asserted.

Configuration
REQ-017 With macro FETCH_SINGLE_STEP_EN defined, ports step_mode and step_pulse SHALL exist.
- With step_mode=1, state STEP_WAIT blocks fetches.
- A step_pulse in STEP_WAIT performs exactly one accepted fetch (REQ-005) and returns to STEP_WAIT.
- Redirect still applies in STEP_WAIT.
- A step_pulse during stall is dropped.
- Clearing step_mode returns the block to RUN next cycle.
REQ-018 Without FETCH_SINGLE_STEP_EN, the step ports SHALL be absent and STEP_WAIT unreachable.

Verification
REQ-019 The bench ROM SHALL model idata = iaddr + 16'h1000, combinational.
REQ-020 Reset then free-run 4 cycles -> if_pc 0000,0002,0004,0006; if_instr 1000,1002,1004,1006; if_valid=1 from the first edge.
REQ-021 Stall for 3 cycles at pc=0x0008 -> if_pc stays 0x0006, iaddr stays 0x0008; release -> next if_pc=0x0008, if_instr=0x1008.
REQ-022 Redirect with redirect_pc=0x0003 and stall=1 together -> pc=0x0002, if_valid=0; next accepted fetch gives if_instr=0x1002.
REQ-023 Force pc to 0xFFFE via redirect -> fetch of if_pc=0xFFFE, if_instr=0x0FFE, then if_pc=0x0000, no stall.
REQ-024 With FETCH_SINGLE_STEP_EN and step_mode=1: reset, wait 10 cycles -> if_valid=0; two step_pulses 5 cycles apart -> if_pc 0000 then 0002, pc held between pulses.
